ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction fetch front end; produces the `{pc, inst}` stream consumed by the decode stage.
- Owns the PC register and issues in-order word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts PC redirects from execute and discards all in-flight and buffered old-stream instructions.

Parameters:
- XLEN, 32, datapath width; also the `XLEN` macro from `defines.v`.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, entries in the `{pc, inst}` output buffer; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered imem requests.

Ports:
- clk_i, input, 1, clock; all state updates on rising edge.
- rst_i, input, 1, reset; asynchronous, active-high.
- imem_req_o, input/output: output, 1, fetch request valid.
- imem_addr_o, output, XLEN, word address of request; bits [1:0] always 0.
- imem_gnt_i, input, 1, request accepted when imem_req_o && imem_gnt_i.
- imem_rvalid_i, input, 1, response data valid; responses return in request order, latency at least 1 cycle.
- imem_rdata_i, input, XLEN, instruction word.
- redirect_i, input, 1, branch/jump taken.
- redirect_pc_i, input, XLEN, new fetch target; bits [1:0] ignored and forced to 0.
- if_valid_o, output, 1, pc_o/inst_o hold a valid instruction.
- id_ready_i, input, 1, decode accepts the entry when if_valid_o && id_ready_i.
- pc_o, output, XLEN, PC of the head instruction.
- inst_o, output, XLEN, head instruction.

Behaviour:
- Reset, asynchronous on rst_i high:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_o = 0; imem_addr_o = RESET_PC.
  - if_valid_o = 0; pc_o = 0; inst_o = 32'h0000_0013 (NOP).
  - Reset mid-transaction abandons all outstanding responses; responses arriving after deassertion are the memory's responsibility to squash.
- First request: imem_req_o rises in the first cycle after rst_i deasserts.
- Issue rule:
  - imem_req_o = (outstanding < MAX_OUTSTANDING) && ((outstanding - drop_cnt) + fifo_count + pending_push < FIFO_DEPTH).
  - This guarantees FIFO space for every live response.
  - imem_addr_o = fetch_pc. Memory samples the address only on req && gnt.
  - On grant: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
  - Req and addr may change without a grant only due to redirect.
- Request PC tracking:
  - An internal in-order queue of depth MAX_OUTSTANDING holds the PC of each granted request.
  - On rvalid, pop that queue and outstanding -= 1.
- Response handling:
  - If drop_cnt > 0: drop_cnt -= 1 and discard the data.
  - Otherwise push `{req_pc, imem_rdata_i}` into the FIFO.
  - Grant and rvalid in the same cycle: outstanding unchanged.
- Output:
  - if_valid_o = FIFO not empty; pc_o/inst_o = FIFO head.
  - When empty: pc_o holds its last value and inst_o = NOP.
  - Pop on if_valid_o && id_ready_i.
  - Push and pop in the same cycle is allowed, including when the FIFO is full. Push on a full FIFO without a pop is unreachable; assert it.
- Redirect (cycle N):
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00} at N+1.
  - FIFO flushed at N+1; a pop in cycle N is ignored.
  - drop_cnt = all requests outstanding after cycle N's updates. This includes a request granted in cycle N, and excludes a response received in cycle N, which is itself discarded.
  - New-stream requests may issue from N+1 while drops drain; ordering keeps them unambiguous.
  - Back-to-back redirects: the later target wins and drop_cnt is recomputed the same way.
- Throughput: with 1-cycle memory latency and decode always ready, one instruction per cycle in steady state.
- Minimum latency, redirect to first new if_valid_o: issue at N+1, response N+2, valid N+3.

Decomposition:
- Shared package or `defines.v` entries: `XLEN`, `NOP_INST` (32'h0000_0013), `INST_ALIGN` (4).
- One sub-module: sync_fifo, parameterised on WIDTH/DEPTH, with push/pop/flush, full/empty and count.
- The output FIFO and the request-PC queue each instantiate sync_fifo.

Test Plan:
- Reset release, 1-cycle memory, id_ready_i=1 -> addresses 0,4,8,... granted each cycle; if_valid_o from cycle 3; pc_o/inst_o match memory image in order.
- id_ready_i=0 for 10 cycles -> FIFO fills to 2 entries; imem_req_o drops once credits are exhausted; no data lost; the stream resumes in order after ready returns.
- Redirect to 0x0000_0102 with 2 requests outstanding, 3-cycle memory latency -> 2 responses dropped; next if_valid_o has pc_o=0x0000_0100; no stale PC ever visible.
- Redirect in the same cycle as a grant and an rvalid -> granted request dropped; the rvalid data is not pushed; drop_cnt correct (check with an assertion).
- fetch_pc=0xFFFF_FFFC, then a grant -> next imem_addr_o = 0x0000_0000.
- rst_i pulsed asynchronously mid-stream -> outputs return to reset values immediately; fetch restarts at RESET_PC one cycle after deassertion.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants, the fetch-entry payload and PC alignment helper for the
// instruction fetch front end.
package ifetch_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_ALIGN = 4;
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INST_ALIGN - 1);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_sync_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. Push on full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem word
// requests under a credit rule, buffers {pc, inst} for decode, handles redirects.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_hold;
  logic [XLEN-1:0] req_pc;
  logic [OCW-1:0]  out_cnt;
  logic [OCW-1:0]  drop_cnt;
  logic [FCW-1:0]  fifo_cnt;
  logic            pcq_full;
  logic            pcq_empty;
  logic            outq_full;
  logic            outq_empty;
  logic            grant;
  logic            rsp;
  logic            push_ent;
  logic            pop_ent;
  logic            issue_ok;
  int unsigned     credits_used;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_ok;

  assign grant    = imem_req_o && imem_gnt_i;
  assign rsp      = imem_rvalid_i && !pcq_empty;
  assign push_ent = rsp && (drop_cnt == '0) && !redirect_i;
  assign pop_ent  = !outq_empty && id_ready_i && !redirect_i;

  always_comb begin
    push_data      = '0;
    push_data.pc   = req_pc;
    push_data.inst = imem_rdata_i;
  end

  // Every live (non-dropped) request owns a FIFO slot; a slot freed by this
  // cycle's pop is reusable so a 1-cycle memory sustains one word per cycle.
  always_comb begin
    credits_used = 32'(out_cnt) - 32'(drop_cnt) + 32'(fifo_cnt) - 32'(pop_ent);
    issue_ok     = (32'(out_cnt) < MAX_OUTSTANDING) && (credits_used < FIFO_DEPTH);
  end

  assign imem_req_o  = !rst_i && issue_ok;
  assign imem_addr_o = fetch_pc;

  // PCs of granted requests, popped in order as responses return.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .pop   (imem_rvalid_i),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (req_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (out_cnt)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_ent),
    .pop   (pop_ent),
    .flush (redirect_i),
    .din   (push_data),
    .dout  (head),
    .full  (outq_full),
    .empty (outq_empty),
    .count (fifo_cnt)
  );

  // On redirect every request still outstanding after this cycle is old-stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      pc_hold  <= '0;
    end else begin
      if (redirect_i)  fetch_pc <= align_pc(redirect_pc_i);
      else if (grant)  fetch_pc <= fetch_pc + XLEN'(INST_ALIGN);
      if (redirect_i)                   drop_cnt <= out_cnt + OCW'(grant) - OCW'(rsp);
      else if (rsp && drop_cnt != '0)   drop_cnt <= drop_cnt - OCW'(1);
      if (!outq_empty) pc_hold <= head.pc;
    end
  end

  assign if_valid_o = !outq_empty;
  assign pc_o       = outq_empty ? pc_hold : head.pc;
  assign inst_o     = outq_empty ? NOP_INST : head.inst;

  assign unused_ok = &{1'b0, pcq_full, outq_full};

  assert property (@(posedge clk_i) disable iff (rst_i) drop_cnt <= out_cnt);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: in-order memory model with random latency and a
// stream scoreboard (expected decode PC / fetch PC sequences).
module tb_ifetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifv;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] inst;

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_valid_o    (ifv),
    .id_ready_i    (ready),
    .pc_o          (pc),
    .inst_o        (inst)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  int          cyc;
  int          lat_min, lat_max, gnt_pct, rdy_pct, rdr_pct;
  logic [31:0] exp_fetch, exp_pc, last_pc;
  int          accepted = 0;
  bit          wrap_armed;
  int          wrap_seen = 0;
  bit          release_rst = 1'b0;
  logic        s_req, s_ifv, s_combo;
  logic [31:0] s_addr, s_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    pend_addr.delete();
    pend_due.delete();
    exp_fetch  = RST_PC;
    exp_pc     = RST_PC;
    last_pc    = 32'h0;
    cyc        = 1;
    wrap_armed = 1'b0;
  endtask

  // One clock: drive inputs after the edge, then check and update at negedge.
  task automatic run_cycle(input bit force_rdr, input logic [31:0] tgt);
    bit grant_s;
    @(posedge clk);
    #1;
    if (release_rst) begin
      rst = 1'b0;
      release_rst = 1'b0;
    end
    gnt         = ($urandom_range(99) < gnt_pct);
    ready       = ($urandom_range(99) < rdy_pct);
    redirect    = force_rdr || ($urandom_range(99) < rdr_pct);
    redirect_pc = force_rdr ? tgt : $urandom();
    rvalid      = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    rdata       = rvalid ? mem_word(pend_addr[0]) : $urandom();
    @(negedge clk);
    if (ifv) begin
      check_eq("head_pc", pc, exp_pc);
      check_eq("head_inst", inst, mem_word(exp_pc));
      last_pc = pc;
    end else begin
      check_eq("idle_inst", inst, NOP);
      check_eq("idle_pc", pc, last_pc);
    end
    grant_s = req && gnt;
    s_req   = req;
    s_ifv   = ifv;
    s_addr  = addr;
    s_pc    = pc;
    s_combo = grant_s && rvalid && redirect;
    if (grant_s) begin
      check_eq("req_addr", addr, exp_fetch);
      if (wrap_armed) begin
        check_eq("wrap_addr", addr, 32'h0);
        wrap_seen++;
        wrap_armed = 1'b0;
      end
      if (addr == 32'hFFFF_FFFC) wrap_armed = 1'b1;
      pend_addr.push_back(addr);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      check_eq("outstanding_max", (pend_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (redirect) begin
      exp_fetch  = redirect_pc & ~32'h3;
      exp_pc     = redirect_pc & ~32'h3;
      wrap_armed = 1'b0;
    end else if (ifv && ready) begin
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(req), 32'd0);
    check_eq({tag, "_addr"}, addr, RST_PC);
    check_eq({tag, "_valid"}, 32'(ifv), 32'd0);
    check_eq({tag, "_pc"}, pc, 32'h0);
    check_eq({tag, "_inst"}, inst, NOP);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] want_pc);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(1'b0, 32'h0);
      if (s_ifv) found = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
    if (found) check_eq({tag, "_pc"}, s_pc, want_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    int a0;
    bit found;
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100; rdr_pct = 0;
    #12;
    check_reset_outputs("reset");
    model_reset();
    release_rst = 1'b1;

    // Reset release with 1-cycle memory and decode always ready
    run_cycle(1'b0, 32'h0);
    check_eq("first_req", 32'(s_req), 32'd1);
    check_eq("first_addr", s_addr, RST_PC);
    run_cycle(1'b0, 32'h0);
    check_eq("valid_cyc2", 32'(s_ifv), 32'd0);
    run_cycle(1'b0, 32'h0);
    check_eq("valid_cyc3", 32'(s_ifv), 32'd1);
    req_cnt = 0;
    a0 = accepted;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 32'h0);
      if (s_req) req_cnt++;
    end
    check_eq("steady_req", 32'(req_cnt), 32'd20);
    check_eq("steady_accept", 32'(accepted - a0), 32'd20);

    // Decode stall: credits run out, stream resumes in order
    rdy_pct = 0;
    repeat (10) run_cycle(1'b0, 32'h0);
    check_eq("stall_req_low", 32'(s_req), 32'd0);
    check_eq("stall_valid", 32'(s_ifv), 32'd1);
    rdy_pct = 100;
    a0 = accepted;
    repeat (10) run_cycle(1'b0, 32'h0);
    check_eq("stall_resume", (accepted - a0 >= 8) ? 32'd1 : 32'd0, 32'd1);

    // Redirect with two requests outstanding, 3-cycle memory
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(1'b0, 32'h0);
      if (pend_addr.size() == 2) found = 1'b1;
    end
    check_eq("two_outstanding", 32'(found), 32'd1);
    run_cycle(1'b1, 32'h0000_0102);
    wait_valid("redir", 32'h0000_0100);

    // Redirect coinciding with a grant and an rvalid
    lat_min = 1; lat_max = 1;
    repeat (5) run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h0000_0200);
    run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h0000_0300);
    check_eq("combo_hit", 32'(s_combo), 32'd1);
    wait_valid("combo_first", 32'h0000_0300);

    // Back-to-back redirects: later target wins
    repeat (3) run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h0000_0400);
    run_cycle(1'b1, 32'h0000_0501);
    wait_valid("b2b_first", 32'h0000_0500);

    // Fetch PC wrap at the top of the address space
    run_cycle(1'b1, 32'hFFFF_FFF8);
    repeat (10) run_cycle(1'b0, 32'h0);
    check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redirect = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    model_reset();
    release_rst = 1'b1;
    run_cycle(1'b0, 32'h0);
    check_eq("restart_req", 32'(s_req), 32'd1);
    check_eq("restart_addr", s_addr, RST_PC);

    // Randomized traffic: latency, grants, decode stalls and redirects
    lat_min = 1; lat_max = 4; gnt_pct = 70; rdy_pct = 70; rdr_pct = 4;
    a0 = accepted;
    repeat (3000) run_cycle(1'b0, 32'h0);
    check_eq("random_progress", (accepted - a0 > 100) ? 32'd1 : 32'd0, 32'd1);
    lat_min = 1; lat_max = 2; gnt_pct = 90; rdy_pct = 90; rdr_pct = 10;
    a0 = accepted;
    repeat (2000) run_cycle(1'b0, 32'h0);
    check_eq("random2_progress", (accepted - a0 > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
